hex_keypad_entry: RTL and testbench

HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/hex_keypad_entry_if.sv | 28 ++
 rtl/key_debounce.sv | 51 +++++
 rtl/hex_keypad_entry.sv | 112 +++++++++++
 tb/tb_hex_keypad_entry.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad entry block: FSM encoding,
// default timing parameters, idle-row constant and a row-index helper.
package keypad_pkg;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int HOLD_CYCLES_DEF = 4;

    // All rows read high (pulled up) when no key in the driven column is down.
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        ACCEPT       = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Index of the lowest-numbered active-low row; 0 when none is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_keypad_entry_if.sv
// Pin bundle of the keypad entry block. The block itself uses the slave
// modport; whatever drives the keypad rows and reads the word uses master.
//
// Handshake: Key_Valid is a one-cycle strobe with no back-pressure. Key_Code
// is valid whenever Key_Valid is high and holds the last accepted key after.
interface hex_keypad_entry_if;
    import keypad_pkg::*;

    logic [3:0]  Row;
    logic [3:0]  Col;
    logic        Sel;
    logic        Clr;
    logic [31:0] Data;
    logic [3:0]  Key_Code;
    logic        Key_Valid;
    state_t      state_dbg;

    modport master (
        output Row, Sel, Clr,
        input  Col, Data, Key_Code, Key_Valid, state_dbg
    );

    modport slave (
        input  Row, Sel, Clr,
        output Col, Data, Key_Code, Key_Valid, state_dbg
    );

endinterface

// File: rtl/key_debounce.sv
// Row synchronizer plus a consecutive-cycle stability counter. The counter
// either watches one selected row for "held low" or the whole row bus for
// "all idle"; it restarts whenever the watched condition breaks or en drops.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_async,
    input  logic       en,
    input  logic       watch_idle,
    input  logic [1:0] row_idx,
    output logic [3:0] row_s,
    output logic       row_ok,
    output logic       stable
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [3:0] row_meta_q, row_meta_d;
    logic [3:0] row_s_q, row_s_d;
    logic [7:0] cnt_q, cnt_d;

    // Synchronizer shift and stability counter next-state.
    always_comb begin
        row_meta_d = row_async;
        row_s_d    = row_meta_q;
        row_ok     = watch_idle ? (row_s_q == ROW_IDLE) : !row_s_q[row_idx];
        stable     = en && row_ok && (cnt_q == DEB_LAST);
        cnt_d      = 8'd0;
        if (en && row_ok && !stable) cnt_d = cnt_q + 8'd1;
    end

    // Synchronizer flops reset to idle so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= ROW_IDLE;
            row_s_q    <= ROW_IDLE;
            cnt_q      <= 8'd0;
        end else begin
            row_meta_q <= row_meta_d;
            row_s_q    <= row_s_d;
            cnt_q      <= cnt_d;
        end
    end

    assign row_s = row_s_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: drives one column low at a time, debounces a
// detected key, emits its code once and shifts it into the selected half
// of a 32-bit word, then waits for a debounced release before rescanning.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic               CLK_S,
    input  logic               RST_N,
    hex_keypad_entry_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  row_q, row_d;
    logic [7:0]  hold_q, hold_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  key_code_q, key_code_d;

    logic [3:0]  row_s;
    logic        row_ok;
    logic        stable;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk        (CLK_S),
        .rst_n      (RST_N),
        .row_async  (bus.Row),
        .en         ((state_q == DEBOUNCE) || (state_q == RELEASE_WAIT)),
        .watch_idle (state_q == RELEASE_WAIT),
        .row_idx    (row_q),
        .row_s      (row_s),
        .row_ok     (row_ok),
        .stable     (stable)
    );

    // FSM next-state, column stepping and data word update.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        hold_d     = 8'd0;
        data_d     = data_q;
        key_code_d = key_code_q;
        case (state_q)
            SCAN: begin
                if (hold_q == HOLD_LAST) begin
                    if (row_s != ROW_IDLE) begin
                        row_d   = lowest_low(row_s);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            DEBOUNCE: begin
                if (!row_ok) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                end else if (stable) begin
                    state_d    = ACCEPT;
                    key_code_d = {row_q, col_q};
                end
            end
            ACCEPT: begin
                state_d = RELEASE_WAIT;
                // The top nibble of the edited half falls off; halves never mix.
                if (bus.Sel) data_d[15:0]  = {data_q[11:0], key_code_q};
                else         data_d[31:16] = {data_q[27:16], key_code_q};
            end
            RELEASE_WAIT: begin
                if (stable) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                end
            end
            default: state_d = SCAN;
        endcase
        if (bus.Clr) data_d = 32'd0;
    end

    // State and datapath registers.
    always_ff @(posedge CLK_S or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= SCAN;
            col_q      <= 2'd0;
            row_q      <= 2'd0;
            hold_q     <= 8'd0;
            data_q     <= 32'd0;
            key_code_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            hold_q     <= hold_d;
            data_q     <= data_d;
            key_code_q <= key_code_d;
        end
    end

    assign bus.Col       = ~(4'b0001 << col_q);
    assign bus.Data      = data_q;
    assign bus.Key_Code  = key_code_q;
    assign bus.Key_Valid = (state_q == ACCEPT);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry: a behavioural 4x4 keypad drives Row
// from Col and a press vector; expected key codes are queued as each key is
// pressed and popped whenever Key_Valid fires.
module tb_hex_keypad_entry;
    import keypad_pkg::*;

    localparam int DEB  = DEB_CYCLES_DEF;
    localparam int HOLD = HOLD_CYCLES_DEF;

    logic CLK_S = 1'b0;
    logic RST_N;

    always #5 CLK_S = ~CLK_S;

    hex_keypad_entry_if ifc();

    hex_keypad_entry #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .CLK_S (CLK_S),
        .RST_N (RST_N),
        .bus   (ifc)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          kv_count = 0;
    logic [3:0]  exp_q[$];
    logic [31:0] exp_data;
    logic [15:0] pressed;
    logic [3:0]  row_v;

    // Keypad model: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_v = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && !ifc.Col[c]) row_v[r] = 1'b0;
            end
        end
    end
    assign ifc.Row = row_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every Key_Valid must match the oldest queued key.
    always @(negedge CLK_S) begin
        logic [3:0] exp_code;
        if (RST_N === 1'b1 && ifc.Key_Valid === 1'b1) begin
            kv_count++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL kv_unexpected: observed Key_Valid with code %0h expected none", ifc.Key_Code);
            end else begin
                exp_code = exp_q.pop_front();
                check("key_code", 32'(ifc.Key_Code), 32'(exp_code));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK_S);
    endtask

    task automatic wait_state(input state_t s, input int budget, input string tag);
        int n;
        n = 0;
        while (ifc.state_dbg !== s && n < budget) begin
            @(negedge CLK_S);
            n++;
        end
        check({tag, "_reached"}, 32'(ifc.state_dbg === s), 32'd1);
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_q.push_back(code);
        if (ifc.Sel) exp_data[15:0]  = {exp_data[11:0], code};
        else         exp_data[31:16] = {exp_data[27:16], code};
    endtask

    task automatic press_release(input int key, input string tag);
        pressed[key] = 1'b1;
        wait_state(RELEASE_WAIT, 100, {tag, "_accept"});
        step(20);
        pressed[key] = 1'b0;
        wait_state(SCAN, 40, {tag, "_release"});
    endtask

    initial begin
        int lat;
        RST_N    = 1'b0;
        ifc.Sel  = 1'b0;
        ifc.Clr  = 1'b0;
        pressed  = 16'd0;
        exp_data = 32'd0;
        step(2);
        check("rst_col",   32'(ifc.Col), 32'h0000000E);
        check("rst_data",  ifc.Data, 32'h0);
        check("rst_code",  32'(ifc.Key_Code), 32'h0);
        check("rst_kv",    32'(ifc.Key_Valid), 32'h0);
        check("rst_state", 32'(ifc.state_dbg), 32'(SCAN));
        RST_N = 1'b1;
        step(1);

        // r=2 c=1 into the upper half
        expect_key(4'd9);
        press_release(9, "k9");
        check("k9_data", ifc.Data, 32'h00090000);
        check("k9_model", ifc.Data, exp_data);
        check("k9_count", 32'(kv_count), 32'd1);

        // lower half: r=3 c=3 then r=0 c=0
        ifc.Sel = 1'b1;
        expect_key(4'd15);
        press_release(15, "k15");
        check("k15_data", ifc.Data, 32'h0009000F);
        expect_key(4'd0);
        press_release(0, "k0");
        check("k0_data", ifc.Data, 32'h000900F0);
        check("k0_count", 32'(kv_count), 32'd3);

        // bounce on r=1 c=2: low for DEB-1 debounce cycles only
        pressed[6] = 1'b1;
        wait_state(DEBOUNCE, 60, "bounce_deb");
        step(1);
        pressed[6] = 1'b0;
        wait_state(SCAN, 20, "bounce_scan");
        check("bounce_col", 32'(ifc.Col), 32'h00000007);
        step(30);
        check("bounce_count", 32'(kv_count), 32'd3);
        check("bounce_data", ifc.Data, exp_data);

        // long hold plus short release glitch on r=1 c=1
        expect_key(4'd5);
        pressed[5] = 1'b1;
        wait_state(RELEASE_WAIT, 60, "hold_accept");
        step(200);
        pressed[5] = 1'b0;
        step(2);
        pressed[5] = 1'b1;
        step(3);
        check("glitch_state", 32'(ifc.state_dbg), 32'(RELEASE_WAIT));
        pressed[5] = 1'b0;
        wait_state(SCAN, 40, "hold_release");
        step(20);
        check("hold_count", 32'(kv_count), 32'd4);
        check("hold_data", ifc.Data, 32'h00090F05);

        // reset while debouncing r=2 c=2; key stays held throughout
        pressed[10] = 1'b1;
        wait_state(DEBOUNCE, 60, "rst_deb");
        RST_N = 1'b0;
        #1;
        check("mid_rst_col",   32'(ifc.Col), 32'h0000000E);
        check("mid_rst_data",  ifc.Data, 32'h0);
        check("mid_rst_state", 32'(ifc.state_dbg), 32'(SCAN));
        check("mid_rst_code",  32'(ifc.Key_Code), 32'h0);
        exp_data = 32'd0;
        step(3);
        RST_N = 1'b1;
        expect_key(4'd10);
        lat = 0;
        while (ifc.Key_Valid !== 1'b1 && lat < 100) begin
            @(negedge CLK_S);
            lat++;
        end
        check("redeb_seen", 32'(ifc.Key_Valid), 32'd1);
        check("redeb_latency", 32'(lat >= 2*HOLD + DEB), 32'd1);
        pressed[10] = 1'b0;
        wait_state(SCAN, 40, "redeb_release");
        check("redeb_data", ifc.Data, 32'h0000000A);
        check("redeb_count", 32'(kv_count), 32'd5);

        // rows 1 and 3 together on c=0, with Clr in the accept cycle
        expect_key(4'd4);
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        wait_state(ACCEPT, 60, "clr_accept");
        ifc.Clr = 1'b1;
        check("clr_kv", 32'(ifc.Key_Valid), 32'd1);
        step(1);
        ifc.Clr = 1'b0;
        exp_data = 32'd0;
        check("clr_data", ifc.Data, 32'h0);
        pressed = 16'd0;
        wait_state(SCAN, 40, "clr_release");
        check("clr_count", 32'(kv_count), 32'd6);
        check("clr_model", ifc.Data, exp_data);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
